bcd_multiplier: RTL and testbench
=================================

# bcd_multiplier

- Iterative 4-digit packed-BCD multiplier producing an 8-digit packed-BCD product.
- Inverse arithmetic unit to the BCD divider in the same datapath; uses the same start/end handshake style.
- Products from this block are fed back into the divider for round-trip checks.
- Uses Horner evaluation, most significant multiplier digit first:
  - one decimal shift per multiplier digit;
  - one BCD addition of the multiplicand per unit of that digit.

## Interface
No parameters; widths are fixed at 4 BCD digits in and 8 BCD digits out.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled on posedge in IDLE or DONE
- multiplicand  input  16  4-digit packed BCD, captured on the accepted start edge
- multiplier  input  16  4-digit packed BCD, captured on the accepted start edge
- product  output  32  8-digit packed BCD result, registered
- end_multiplication  output  1  high while in DONE
- busy  output  1  high in SHIFT or ADD

## Operation
- **Registers**
  - mcand: 16 bits.
  - mplr: 16 bits.
  - acc: 32 bits, BCD.
  - idx: 2 bits, digit index.
  - count: 4 bits, remaining adds.
  - state.
- **States**
  - IDLE: wait for start.
  - SHIFT: decimal shift plus load of the next digit count.
  - ADD: repeated BCD addition.
  - DONE: result held.
- **IDLE/DONE with start=1**
  - Capture both operands; acc<=0; idx<=3; go to SHIFT.
  - end_multiplication drops on that edge.
- **SHIFT**
  - acc<=acc<<4 (multiply by 10; the top nibble is always 0 here).
  - count<=mplr digit[idx].
  - If that digit is nonzero, go to ADD.
  - Else if idx==0, go to DONE.
  - Else idx<=idx-1 and stay in SHIFT.
- **ADD**
  - acc<=acc+mcand as an 8-digit BCD add: per-nibble +6 correction when a nibble sum is >9, carry ripples through all 8 digits.
  - count<=count-1.
  - When count==1: go to DONE if idx==0; otherwise idx<=idx-1 and go to SHIFT.
- **Entry to DONE:** product<=final acc value, i.e. the acc value including the last add.
  - product is written only on this transition; it holds between operations.
- **Overflow:** impossible by construction, since the maximum is 9999*9999 = 99980001.
- **Non-BCD nibbles (>9) in operands:** undefined result; no detection in this block.
- **start while busy:** ignored, and the operands are not re-sampled.
- **Inputs:** may change freely after the capture edge.
- **rst** (asynchronous, any state, including mid-operation):
  - state=IDLE; product=0; end_multiplication=0; busy=0; acc, mcand, mplr, idx and count cleared.

## Timing
- **Capture edge E0:** start is accepted on E0.
- **Latency:** with S = sum of the four multiplier digits, DONE is entered on edge E0+4+S.
  - end_multiplication and the new product are visible after that edge.
  - Range: 4 cycles (multiplier 0000) to 40 cycles (multiplier 9999).
- **busy:** high from after E0 until the edge that enters DONE.
- **end_multiplication:** stays high in DONE until the next accepted start or rst.
- **Back-to-back operation:** start held high in DONE restarts on the very next edge, so there is zero idle cycles between operations.
- **Level sensitivity:** start is level-sampled. If start is held high across DONE, a new operation begins on the same edge as the one after DONE entry; the bench pulses start for one cycle.

## Configuration
- **BCD_MULT_ZERO_SKIP_EN defined**
  - Applies on the capture edge when multiplicand==0 or multiplier==0.
  - Go directly to DONE with product<=0; latency is 1 edge and busy never asserts.
- **BCD_MULT_ZERO_SKIP_EN undefined:** the normal sequence always runs.
  - Multiplier 0000 takes 4 edges.
  - Multiplicand 0000 takes 4+S edges, adding zeros.
  - Product is 0 in both cases.

## Test plan
- **Basic multiply:** multiplicand 0012, multiplier 0034, start pulse.
  - product=00000408; end_multiplication after exactly 11 edges; busy high for those cycles.
- **Maximum operands:** 9999 × 9999.
  - product=99980001 after 40 edges; exercises the BCD carry chain across all digits.
- **Zero operands:**
  - 0150 × 0000: product=00000000 after 4 edges (macro off) or 1 edge (macro on).
  - 0000 × 0005: product=00000000 after 9 edges (macro off) or 1 edge (macro on).
- **Start while busy:** 0025 × 0007 started; start re-pulsed with 0999 × 0999 at edge E0+3.
  - Ignored: product=00000175 after 11 edges.
  - Then a restart from DONE with 0144 × 0009 gives 00001296 after 13 edges.
- **Reset mid-operation:** rst asserted between edges during 0123 × 0004.
  - product=0, end_multiplication=0 and busy=0 immediately, without waiting for a clock edge.
  - After release, 0050 × 0003 returns 00000150 after 7 edges.

Source files
------------

// File: rtl/bcd_multiplier.sv
// bcd_multiplier: iterative 4-digit packed-BCD multiplier, 8-digit packed-BCD product.
// Horner evaluation, most significant multiplier digit first: one decimal
// shift per digit, then one BCD add of the multiplicand per unit of that digit.
// Optional feature: define BCD_MULT_ZERO_SKIP_EN to finish on the capture edge
// when either operand is zero.
module bcd_multiplier (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] multiplicand,
  input  logic [15:0] multiplier,
  output logic [31:0] product,
  output logic        end_multiplication,
  output logic        busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] ADD   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]  state;
  logic [15:0] mcand;
  logic [15:0] mplr;
  logic [31:0] acc;
  logic [1:0]  idx;
  logic [3:0]  count;

  logic [3:0]  digit;
  logic [31:0] acc_shift;
  logic [31:0] acc_sum;

  // 8-digit BCD add with per-nibble +6 correction and rippling decimal carry
  function automatic logic [31:0] bcd_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] s;
    logic        c;
    logic [4:0]  d;
    s = '0;
    c = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      d = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0000, c};
      if (d > 5'd9) begin
        d = d + 5'd6;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      s[4*i +: 4] = d[3:0];
    end
    return s;
  endfunction

  // Current multiplier digit, decimal shift and accumulate candidates
  always_comb begin
    digit     = mplr[{idx, 2'b00} +: 4];
    acc_shift = {acc[27:0], 4'h0};
    acc_sum   = bcd_add(acc, {16'h0000, mcand});
  end

  // Sequencer: operand capture, shift/add iteration and result latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      mcand   <= '0;
      mplr    <= '0;
      acc     <= '0;
      idx     <= '0;
      count   <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            mcand <= multiplicand;
            mplr  <= multiplier;
            acc   <= '0;
            idx   <= 2'd3;
`ifdef BCD_MULT_ZERO_SKIP_EN
            if (multiplicand == 16'h0000 || multiplier == 16'h0000) begin
              state   <= DONE;
              product <= '0;
            end else begin
              state <= SHIFT;
            end
`else
            state <= SHIFT;
`endif
          end
        end
        SHIFT: begin
          acc   <= acc_shift;
          count <= digit;
          if (digit != 4'd0) begin
            state <= ADD;
          end else if (idx == 2'd0) begin
            state   <= DONE;
            product <= acc_shift;
          end else begin
            idx <= idx - 2'd1;
          end
        end
        ADD: begin
          acc   <= acc_sum;
          count <= count - 4'd1;
          if (count == 4'd1) begin
            if (idx == 2'd0) begin
              state   <= DONE;
              product <= acc_sum;
            end else begin
              idx   <= idx - 2'd1;
              state <= SHIFT;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Status flags decoded straight from state so reset clears them at once
  always_comb begin
    busy               = (state == SHIFT) || (state == ADD);
    end_multiplication = (state == DONE);
  end

endmodule

// File: tb/tb_bcd_multiplier.sv
// Scoreboard bench for bcd_multiplier: driver pushes expected product and
// latency computed from integer arithmetic; a negedge monitor pops and checks.
module tb_bcd_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] multiplicand = '0;
  logic [15:0] multiplier = '0;
  logic [31:0] product;
  logic        end_multiplication;
  logic        busy;

  bcd_multiplier dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .multiplicand(multiplicand),
    .multiplier(multiplier),
    .product(product),
    .end_multiplication(end_multiplication),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] prod;
    int          lat;
    int          e0;
    logic [15:0] a;
    logic [15:0] b;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   last_done = -1;
  int   vectors = 0;
  int   errors = 0;

  always @(posedge clk) cyc = cyc + 1;

  function automatic int bcd2int(input logic [15:0] v);
    int r = 0;
    for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [31:0] int2bcd(input int v);
    logic [31:0] r = '0;
    int t = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [15:0] rand_bcd4();
    logic [15:0] r;
    for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  // Issue one operation once the DUT is not busy; record expectation at E0
  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int   ia, ib, s, w;
    w = 0;
    @(negedge clk);
    while (busy && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (busy) begin
      $display("FAIL issue_wait: busy=%0b after %0d cycles, required 0", busy, w);
      errors++;
    end
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    @(posedge clk);
    #1;
    ia = bcd2int(a);
    ib = bcd2int(b);
    s  = 0;
    for (int t = ib; t > 0; t = t / 10) s += t % 10;
    e.prod = int2bcd(ia * ib);
    e.lat  = 4 + s;
`ifdef BCD_MULT_ZERO_SKIP_EN
    if (ia == 0 || ib == 0) e.lat = 0;
`endif
    e.e0 = cyc;
    e.a  = a;
    e.b  = b;
    q.push_back(e);
    start = 1'b0;
  endtask

  // Monitor: completion detection, product/latency check, busy-while-running
  always @(negedge clk) begin
    exp_t h;
    if (!rst && q.size() > 0) begin
      h = q[0];
      if (end_multiplication && h.e0 > last_done) begin
        vectors++;
        if (product !== h.prod) begin
          $display("FAIL product %h x %h: got %h, required %h", h.a, h.b, product, h.prod);
          errors++;
        end
        vectors++;
        if (cyc - h.e0 != h.lat) begin
          $display("FAIL latency %h x %h: got %0d edges after E0, required %0d",
                   h.a, h.b, cyc - h.e0, h.lat);
          errors++;
        end
        void'(q.pop_front());
        last_done = cyc;
      end else if (cyc - h.e0 > 60) begin
        $display("FAIL timeout %h x %h: no end_multiplication after %0d cycles, required %0d",
                 h.a, h.b, cyc - h.e0, h.lat);
        errors++;
        vectors++;
        void'(q.pop_front());
        last_done = cyc;
      end else if (cyc >= h.e0) begin
        vectors++;
        if (busy !== 1'b1) begin
          $display("FAIL busy %h x %h: got %b at %0d edges after E0, required 1",
                   h.a, h.b, busy, cyc - h.e0);
          errors++;
        end
      end
    end
  end

  task automatic check_idle_outputs(input string name);
    vectors += 3;
    if (product !== 32'h0) begin
      $display("FAIL %s product: got %h, required 00000000", name, product);
      errors++;
    end
    if (end_multiplication !== 1'b0) begin
      $display("FAIL %s end_multiplication: got %b, required 0", name, end_multiplication);
      errors++;
    end
    if (busy !== 1'b0) begin
      $display("FAIL %s busy: got %b, required 0", name, busy);
      errors++;
    end
  endtask

  initial begin
    int w;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset_state");
    rst = 1'b0;

    issue(16'h0012, 16'h0034);
    issue(16'h9999, 16'h9999);
    issue(16'h0150, 16'h0000);
    issue(16'h0000, 16'h0005);

    // start re-pulsed while busy must be ignored
    issue(16'h0025, 16'h0007);
    repeat (3) @(negedge clk);
    multiplicand = 16'h0999;
    multiplier   = 16'h0999;
    start        = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    issue(16'h0144, 16'h0009);

    // asynchronous reset mid-operation
    issue(16'h0123, 16'h0004);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_idle_outputs("async_reset");
    q.delete();
    last_done = -1;
    @(negedge clk);
    rst = 1'b0;
    issue(16'h0050, 16'h0003);

    // randomized operands with random gaps (gap 0 restarts straight from DONE)
    for (int n = 0; n < 25; n++) begin
      logic [15:0] a, b;
      a = rand_bcd4();
      b = rand_bcd4();
      if ($urandom_range(0, 7) == 0) a = '0;
      if ($urandom_range(0, 7) == 0) b = '0;
      issue(a, b);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    w = 0;
    while (q.size() > 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (q.size() > 0) begin
      $display("FAIL drain: %0d operations outstanding, required 0", q.size());
      errors++;
      vectors++;
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
